// File: rtl/alu_wb_pkg.sv
// Shared types and defaults for the ALU execute/writeback stage.
// Opcode and FSM state encodings live here so the stage and its bench agree.
package alu_wb_pkg;

  localparam int ALU_WB_RWIDTH = 6;
  localparam int ALU_WB_DWIDTH = 32;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

  // Opcodes 0..7 complete in one cycle and always write a result.
  function automatic logic is_single(input logic [3:0] op);
    return (op <= 4'(OP_SRL));
  endfunction

endpackage

// File: rtl/alu_wb_stage_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle.
// A start pulse captures the operands; done pulses once the product is final.
module mul_iter #(
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DWIDTH-1:0] a,
  input  logic [DWIDTH-1:0] b,
  output logic              done,
  output logic [DWIDTH-1:0] product
);

  localparam int CW = $clog2(DWIDTH) + 1;

  logic [DWIDTH-1:0] ma;
  logic [DWIDTH-1:0] mb;
  logic [DWIDTH-1:0] acc;
  logic [CW-1:0]     cnt;
  logic              active;

  // Operand capture, one shift-add step per cycle, and iteration counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      ma     <= '0;
      mb     <= '0;
      acc    <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      ma     <= a;
      mb     <= b;
      acc    <= '0;
      cnt    <= CW'(DWIDTH);
      active <= 1'b1;
    end else if (active) begin
      if (cnt != '0) begin
        if (mb[0]) begin
          acc <= acc + ma;
        end
        ma  <= ma << 1;
        mb  <= mb >> 1;
        cnt <= cnt - 1'b1;
      end else begin
        active <= 1'b0;
      end
    end
  end

  assign done    = active && (cnt == '0);
  assign product = acc;

endmodule

// File: rtl/alu_wb_stage.sv
// Execute/writeback stage feeding the register-file write port.
// Single-cycle ops issue every cycle; MUL is iterative and stalls via in_ready.
// Define ALU_WB_MUL_EN to build the multiplier; otherwise opcode 8 is illegal.
module alu_wb_stage
  import alu_wb_pkg::*;
#(
  parameter int RWIDTH = ALU_WB_RWIDTH,
  parameter int DWIDTH = ALU_WB_DWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [DWIDTH-1:0] rd1,
  input  logic [DWIDTH-1:0] rd2,
  input  logic [RWIDTH-1:0] dst,
  output logic [RWIDTH-1:0] wa,
  output logic [DWIDTH-1:0] wd,
  output logic              we,
  output logic              busy
);

  localparam int SW = $clog2(DWIDTH);

  state_e            state;
  state_e            state_next;
  logic              accept;
  logic              we_next;
  logic [RWIDTH-1:0] wa_next;
  logic [DWIDTH-1:0] wd_next;
  logic [DWIDTH-1:0] alu_res;
  logic [SW-1:0]     shamt;

`ifdef ALU_WB_MUL_EN
  logic              mul_start;
  logic              mul_done;
  logic [DWIDTH-1:0] mul_prod;
  logic [RWIDTH-1:0] mul_dst;
`endif

  assign in_ready = (state == IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign shamt    = rd2[SW-1:0];

  // Combinational result of the single-cycle operations.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD: alu_res = rd1 + rd2;
      OP_SUB: alu_res = rd1 - rd2;
      OP_AND: alu_res = rd1 & rd2;
      OP_OR:  alu_res = rd1 | rd2;
      OP_XOR: alu_res = rd1 ^ rd2;
      OP_SLT: alu_res = {{(DWIDTH-1){1'b0}}, ($signed(rd1) < $signed(rd2))};
      OP_SLL: alu_res = rd1 << shamt;
      OP_SRL: alu_res = rd1 >> shamt;
      default: alu_res = '0;
    endcase
  end

  // Next-state and next write-port values; illegal ops fall through with no write.
  always_comb begin
    state_next = state;
    we_next    = 1'b0;
    wa_next    = wa;
    wd_next    = wd;
`ifdef ALU_WB_MUL_EN
    mul_start  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_single(op)) begin
            we_next = 1'b1;
            wa_next = dst;
            wd_next = alu_res;
          end
`ifdef ALU_WB_MUL_EN
          else if (op == 4'(OP_MUL)) begin
            mul_start  = 1'b1;
            state_next = MUL;
          end
`endif
        end
      end
`ifdef ALU_WB_MUL_EN
      MUL: begin
        if (mul_done) begin
          state_next = IDLE;
          we_next    = 1'b1;
          wa_next    = mul_dst;
          wd_next    = mul_prod;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // State and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      we    <= 1'b0;
      wa    <= '0;
      wd    <= '0;
    end else begin
      state <= state_next;
      we    <= we_next;
      wa    <= wa_next;
      wd    <= wd_next;
    end
  end

`ifdef ALU_WB_MUL_EN
  // Destination held for the duration of the multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_dst <= '0;
    end else if (mul_start) begin
      mul_dst <= dst;
    end
  end

  mul_iter #(
    .DWIDTH (DWIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (rd1),
    .b       (rd2),
    .done    (mul_done),
    .product (mul_prod)
  );

  assign busy = (state == MUL);
`else
  assign busy = 1'b0;
`endif

endmodule
